// File: rtl/player_sprite_drawer_pkg.sv
// Shared types and constants for the player sprite drawer: FSM states,
// 3-bit colour names, screen bounds and the latched draw command.
package player_sprite_drawer_pkg;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] spr_c;
    logic [2:0] bg_c;
  } draw_cmd_t;
endpackage

// File: rtl/player_sprite_drawer_if.sv
// Pixel stream produced by one user's sprite drawer, consumed by the
// object-to-paint selector.
interface player_sprite_drawer_if;
  logic [8:0] VGA_X;
  logic [7:0] VGA_Y;
  logic [2:0] VGA_COLOR;
  logic       plot_enable;

  modport master (output VGA_X, VGA_Y, VGA_COLOR, plot_enable);
  modport slave  (input  VGA_X, VGA_Y, VGA_COLOR, plot_enable);
endinterface

// File: rtl/player_sprite_drawer_mask_rom.sv
// Combinational sprite shape: a filled box with its four corners knocked out.
module sprite_mask_rom
  import player_sprite_drawer_pkg::*;
#(
  parameter int SPR_W = 8,
  parameter int SPR_H = 8
) (
  input  logic [7:0] row,
  input  logic [8:0] col,
  output logic       mask
);
  logic edge_r, edge_c;

  assign edge_r = (row == 8'd0) || (row == 8'(SPR_H - 1));
  assign edge_c = (col == 9'd0) || (col == 9'(SPR_W - 1));
  assign mask   = !(edge_r && edge_c);
endmodule

// File: rtl/player_sprite_drawer.sv
// Erases the sprite at its old position with the background colour, then
// draws it at the new one, one clipped pixel per clock.
module player_sprite_drawer #(
  parameter int SPR_W    = 8,
  parameter int SPR_H    = 8,
  parameter int SCREEN_W = player_sprite_drawer_pkg::SCREEN_W,
  parameter int SCREEN_H = player_sprite_drawer_pkg::SCREEN_H,
  parameter int INIT_X   = 40,
  parameter int INIT_Y   = 100
) (
  input  logic                          CLOCK_50,
  input  logic                          rstn,
  input  logic                          draw_req,
  input  logic [8:0]                    new_x,
  input  logic [7:0]                    new_y,
  input  logic [2:0]                    sprite_color,
  input  logic [2:0]                    background_color,
  output logic                          busy,
  output logic                          frame_done,
  player_sprite_drawer_if.master        pix
);
  import player_sprite_drawer_pkg::*;

  localparam int WH = SPR_W * SPR_H;
  localparam int CW = (WH > 1) ? $clog2(WH) : 1;

  state_t          state, state_nxt;
  draw_cmd_t       cmd;
  logic [CW-1:0]   cnt;
  logic [8:0]      old_x, base_x, col;
  logic [7:0]      old_y, base_y, row;
  logic [9:0]      sum_x;
  logic [8:0]      sum_y;
  logic            first_draw, mask, last, on_screen, same_pos;

  assign col       = 9'(int'(cnt) % SPR_W);
  assign row       = 8'(int'(cnt) / SPR_W);
  assign last      = (cnt == CW'(WH - 1));
  assign same_pos  = (new_x == old_x) && (new_y == old_y);
  assign base_x    = (state == ERASE) ? old_x : cmd.x;
  assign base_y    = (state == ERASE) ? old_y : cmd.y;
  // One extra bit so off-screen positions are not hidden by wraparound.
  assign sum_x     = {1'b0, base_x} + {1'b0, col};
  assign sum_y     = {1'b0, base_y} + {1'b0, row};
  assign on_screen = (sum_x < 10'(SCREEN_W)) && (sum_y < 9'(SCREEN_H));

  sprite_mask_rom #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_mask (
    .row  (row),
    .col  (col),
    .mask (mask)
  );

  always_ff @(posedge CLOCK_50 or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (draw_req) state_nxt = (first_draw || same_pos) ? DRAW : ERASE;
      ERASE:   if (last) state_nxt = DRAW;
      DRAW:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rstn) begin
    if (!rstn) begin
      pix.VGA_X       <= '0;
      pix.VGA_Y       <= '0;
      pix.VGA_COLOR   <= '0;
      pix.plot_enable <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      cnt             <= '0;
      cmd             <= '0;
      old_x           <= 9'(INIT_X);
      old_y           <= 8'(INIT_Y);
      first_draw      <= 1'b1;
    end else begin
      pix.plot_enable <= 1'b0;
      frame_done      <= (state == DONE);
      // Stays up through the frame_done cycle so the pulse is seen as busy.
      busy            <= (state_nxt != IDLE) || (state == DONE);
      case (state)
        IDLE: if (draw_req) begin
          cmd <= '{x: new_x, y: new_y, spr_c: sprite_color, bg_c: background_color};
          cnt <= '0;
        end
        ERASE, DRAW: begin
          pix.VGA_X       <= sum_x[8:0];
          pix.VGA_Y       <= sum_y[7:0];
          pix.VGA_COLOR   <= (state == ERASE) ? cmd.bg_c : cmd.spr_c;
          pix.plot_enable <= mask && on_screen;
          cnt             <= last ? '0 : cnt + 1'b1;
        end
        DONE: begin
          old_x      <= cmd.x;
          old_y      <= cmd.y;
          first_draw <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
